// File: rtl/decoder_round_controller.sv
// decoder_round_controller
// Round sequencer for the union-find grid: loads one syndrome frame, times the
// start/stop offer window, then snapshots the grid and streams one result beat
// per defect (or a single "none" beat) over a valid/ready interface.
module decoder_round_controller #(
  parameter int GRID_ROWS         = 4,
  parameter int GRID_COLS         = 5,
  parameter int CORDINATE_WIDTH   = 3,
  parameter int MATCH_VALUE_WIDTH = 6,
  parameter int SETTLE_CYCLES     = 100,
  parameter int OFFER_CYCLES      = 2500
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [GRID_ROWS*GRID_COLS-1:0]                    syndrome_in,
  input  logic                                              syndrome_valid,
  output logic                                              syndrome_ready,
  output logic [GRID_ROWS*GRID_COLS-1:0]                    measurement_value_out,
  output logic                                              measurement_valid_out,
  output logic                                              start_offer,
  output logic                                              stop_offer,
  input  logic [GRID_ROWS*GRID_COLS-1:0]                    measurement_in,
  input  logic [GRID_ROWS*GRID_COLS*MATCH_VALUE_WIDTH-1:0]  match_value_in,
  output logic                                              result_valid,
  input  logic                                              result_ready,
  output logic [CORDINATE_WIDTH-1:0]                        result_y,
  output logic [CORDINATE_WIDTH-1:0]                        result_x,
  output logic [CORDINATE_WIDTH-1:0]                        result_match_y,
  output logic [CORDINATE_WIDTH-1:0]                        result_match_x,
  output logic                                              result_last,
  output logic                                              result_none,
  output logic                                              busy
);

  localparam int N       = GRID_ROWS * GRID_COLS;
  localparam int CW      = CORDINATE_WIDTH;
  localparam int MVW     = MATCH_VALUE_WIDTH;
  localparam int MAX_CYC = (SETTLE_CYCLES > OFFER_CYCLES) ? SETTLE_CYCLES : OFFER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(N);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFFER_LOAD  = CNT_W'(OFFER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N - 1);
  localparam logic [CW-1:0]    COL_LAST    = CW'(GRID_COLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_START, S_RUN, S_STOP, S_CAPTURE, S_SCAN, S_EMIT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       snap_meas;
  logic [N*MVW-1:0]   snap_match;
  logic [IDX_W-1:0]   scan_idx;
  logic [CW-1:0]      scan_row;
  logic [CW-1:0]      scan_col;
  logic               emitted;

  // Scan helpers: current snapshot bit, whether any defect lies beyond it,
  // its match slice, and the row/column pair of the following index.
  logic               cur_bit;
  logic               any_above;
  logic [N-1:0]       shifted;
  logic [MVW-1:0]     cur_match;
  logic               idx_last;
  logic [CW-1:0]      next_row;
  logic [CW-1:0]      next_col;
  logic               handshake;

  assign shifted   = snap_meas >> scan_idx;
  assign cur_bit   = shifted[0];
  assign any_above = |shifted[N-1:1];
  assign cur_match = snap_match[int'(scan_idx)*MVW +: MVW];
  assign idx_last  = (scan_idx == IDX_LAST);
  assign next_col  = (scan_col == COL_LAST) ? '0 : scan_col + 1'b1;
  assign next_row  = (scan_col == COL_LAST) ? scan_row + 1'b1 : scan_row;
  assign handshake = result_valid && result_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode for the round sequence.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (syndrome_valid) state_next = S_LOAD;
      S_LOAD:    state_next = S_SETTLE;
      S_SETTLE:  if (cnt == '0) state_next = S_START;
      S_START:   state_next = S_RUN;
      S_RUN:     if (cnt == '0) state_next = S_STOP;
      S_STOP:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SCAN;
      S_SCAN: begin
        if (cur_bit)       state_next = S_EMIT;
        else if (idx_last) state_next = emitted ? S_IDLE : S_EMIT;
      end
      S_EMIT:    if (result_ready) state_next = result_last ? S_IDLE : S_SCAN;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; ready is also held low during reset.
  always_comb begin
    syndrome_ready        = 1'b0;
    measurement_valid_out = 1'b0;
    start_offer           = 1'b0;
    stop_offer            = 1'b0;
    result_valid          = 1'b0;
    busy                  = (state != S_IDLE);
    unique case (state)
      S_IDLE:  syndrome_ready        = reset;
      S_LOAD:  measurement_valid_out = 1'b1;
      S_START: start_offer           = 1'b1;
      S_STOP:  stop_offer            = 1'b1;
      S_EMIT:  result_valid          = 1'b1;
      default: ;
    endcase
  end

  // Datapath: frame register, window counter, grid snapshot, scan position and result beat.
  // NOTE: the snapshot registers are reset along with everything else so an
  // aborted round never leaks stale grid data into a later scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      measurement_value_out <= '0;
      cnt                   <= '0;
      snap_meas             <= '0;
      snap_match            <= '0;
      scan_idx              <= '0;
      scan_row              <= '0;
      scan_col              <= '0;
      emitted               <= 1'b0;
      result_y              <= '0;
      result_x              <= '0;
      result_match_y        <= '0;
      result_match_x        <= '0;
      result_last           <= 1'b0;
      result_none           <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:   if (syndrome_valid) measurement_value_out <= syndrome_in;
        S_LOAD:   cnt <= SETTLE_LOAD;
        S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        S_START:  cnt <= OFFER_LOAD;
        S_RUN:    if (cnt != '0) cnt <= cnt - 1'b1;
        S_CAPTURE: begin
          snap_meas   <= measurement_in;
          snap_match  <= match_value_in;
          scan_idx    <= '0;
          scan_row    <= '0;
          scan_col    <= '0;
          emitted     <= 1'b0;
          result_none <= 1'b0;
        end
        S_SCAN: begin
          if (cur_bit) begin
            result_y       <= scan_row;
            result_x       <= scan_col;
            result_match_y <= cur_match[MVW-1:CW];
            result_match_x <= cur_match[CW-1:0];
            result_last    <= !any_above;
            result_none    <= 1'b0;
            emitted        <= 1'b1;
          end else if (idx_last) begin
            // Empty round: a single all-zero beat flagged none and last.
            result_y       <= '0;
            result_x       <= '0;
            result_match_y <= '0;
            result_match_x <= '0;
            result_last    <= 1'b1;
            result_none    <= !emitted;
          end else begin
            scan_idx <= scan_idx + 1'b1;
            scan_row <= next_row;
            scan_col <= next_col;
          end
        end
        S_EMIT: begin
          if (handshake && !result_last) begin
            scan_idx <= scan_idx + 1'b1;
            scan_row <= next_row;
            scan_col <= next_col;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_round_controller.sv
// Scoreboard bench for decoder_round_controller: stimulus pushes expected
// frames and result beats into queues; a monitor pops and compares them.
module tb_decoder_round_controller;

  localparam int S   = 100;
  localparam int O   = 2500;
  localparam int N   = 20;
  localparam int CW  = 3;
  localparam int MVW = 6;

  localparam logic [N-1:0] FRAME5 = 20'h0B003;  // nodes 0,1,12,13,15
  localparam logic [N-1:0] EMPTY  = '0;

  typedef struct packed {
    logic [CW-1:0] y;
    logic [CW-1:0] x;
    logic [CW-1:0] my;
    logic [CW-1:0] mx;
    logic          last;
    logic          none;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      syndrome_in;
  logic              syndrome_valid;
  logic              syndrome_ready;
  logic [N-1:0]      measurement_value_out;
  logic              measurement_valid_out;
  logic              start_offer;
  logic              stop_offer;
  logic [N-1:0]      measurement_in;
  logic [N*MVW-1:0]  match_value_in;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [CW-1:0]     result_y, result_x, result_match_y, result_match_x;
  logic              result_last, result_none, busy;

  logic [N*MVW-1:0]  match_tab;
  logic              bp_mode;

  beat_t        exp_q[$];
  logic [N-1:0] frame_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int accept_n = 0, last_n = 0, aborted_n = 0;
  int mv_n = 0, start_n = 0, stop_n = 0;
  int acc_cyc = 0, mv_cyc = 0, start_cyc = 0, stop_cyc = 0;

  decoder_round_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .syndrome_in           (syndrome_in),
    .syndrome_valid        (syndrome_valid),
    .syndrome_ready        (syndrome_ready),
    .measurement_value_out (measurement_value_out),
    .measurement_valid_out (measurement_valid_out),
    .start_offer           (start_offer),
    .stop_offer            (stop_offer),
    .measurement_in        (measurement_in),
    .match_value_in        (match_value_in),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .result_y              (result_y),
    .result_x              (result_x),
    .result_match_y        (result_match_y),
    .result_match_x        (result_match_x),
    .result_last           (result_last),
    .result_none           (result_none),
    .busy                  (busy)
  );

  // Grid stub: reports the loaded frame as its measurement flags.
  assign measurement_in = measurement_value_out;
  assign match_value_in = match_tab;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int y, input int x, input int my, input int mx,
                               input bit last, input bit none);
    beat_t b;
    b.y = CW'(y); b.x = CW'(x); b.my = CW'(my); b.mx = CW'(mx);
    b.last = last; b.none = none;
    return b;
  endfunction

  task automatic push_five();
    exp_q.push_back(mk(0, 0, 0, 1, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 1, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 2, 2, 3, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 3, 2, 2, 1'b0, 1'b0));
    exp_q.push_back(mk(3, 0, 3, 0, 1'b1, 1'b0));
  endtask

  // Cycle counter used to timestamp events.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result-ready driver: always ready, or ready one cycle in three.
  initial forever begin
    @(posedge clk);
    #1;
    result_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each event.
  initial begin
    logic         acc_now, acc_prev, stall;
    logic [N-1:0] mv_prev;
    beat_t        cur, held, e;
    acc_prev = 1'b0; stall = 1'b0; mv_prev = '0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        acc_now = syndrome_valid && syndrome_ready;
        if (measurement_value_out !== mv_prev)
          check("mvo_changes_only_at_accept", 32'(acc_prev), 32'(1));
        if (measurement_valid_out) begin
          mv_n++; mv_cyc = cyc;
          if (frame_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mvo_frame: load pulse with no frame expected");
          end else begin
            check("mvo_frame", 32'(measurement_value_out), 32'(frame_q.pop_front()));
          end
        end
        if (start_offer) begin start_n++; start_cyc = cyc; end
        if (stop_offer)  begin stop_n++;  stop_cyc  = cyc; end
        if (acc_now) begin
          check("accept_only_after_last_beat", 32'(last_n + aborted_n), 32'(accept_n));
          accept_n++; acc_cyc = cyc;
        end
        if (result_valid) begin
          cur = {result_y, result_x, result_match_y, result_match_x, result_last, result_none};
          if (stall) check("fields_stable_under_backpressure", 32'(cur), 32'(held));
          if (result_ready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL beat: unexpected beat %0h", cur);
            end else begin
              e = exp_q.pop_front();
              check("beat", 32'(cur), 32'(e));
            end
            if (result_last) last_n++;
            stall = 1'b0;
          end else begin
            held = cur; stall = 1'b1;
          end
        end else begin
          if (stall) begin
            checks++; errors++;
            $display("FAIL valid_held: result_valid dropped without handshake");
          end
          stall = 1'b0;
        end
        acc_prev = acc_now;
      end else begin
        stall = 1'b0; acc_prev = 1'b0;
      end
      mv_prev = measurement_value_out;
    end
  end

  task automatic wait_accept(input int target);
    for (int k = 0; k < 4000 && accept_n < target; k++) begin
      @(posedge clk);
      #1;
    end
    check("accept_seen", 32'(accept_n), 32'(target));
  endtask

  task automatic offer(input logic [N-1:0] frame);
    int base;
    base = accept_n;
    frame_q.push_back(frame);
    @(posedge clk);
    #1;
    syndrome_in    = frame;
    syndrome_valid = 1'b1;
    wait_accept(base + 1);
    syndrome_valid = 1'b0;
  endtask

  task automatic wait_last(input int target);
    for (int k = 0; k < 6000 && last_n < target; k++) @(negedge clk);
    check("round_done", 32'(last_n), 32'(target));
  endtask

  initial begin
    int m0, s0, p0, base;
    reset = 1'b0; syndrome_valid = 1'b0; syndrome_in = '0; bp_mode = 1'b0;
    for (int k = 0; k < N; k++) match_tab[k*MVW +: MVW] = 6'h3F;
    match_tab[0*MVW  +: MVW] = {3'd0, 3'd1};
    match_tab[1*MVW  +: MVW] = {3'd0, 3'd0};
    match_tab[12*MVW +: MVW] = {3'd2, 3'd3};
    match_tab[13*MVW +: MVW] = {3'd2, 3'd2};
    match_tab[15*MVW +: MVW] = {3'd3, 3'd0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_syndrome_ready", 32'(syndrome_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pulses", 32'({measurement_valid_out, start_offer, stop_offer}), 32'(0));
    check("rst_result", 32'({result_valid, result_last, result_none}), 32'(0));
    check("rst_mvo", 32'(measurement_value_out), 32'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(syndrome_ready), 32'(1));

    // Round 1: five defects, full-rate ready, window timing.
    m0 = mv_n; s0 = start_n; p0 = stop_n;
    push_five();
    offer(FRAME5);
    wait_last(1);
    check("t_mv", 32'(mv_cyc - acc_cyc), 32'(1));
    check("t_start", 32'(start_cyc - acc_cyc), 32'(S + 2));
    check("t_stop", 32'(stop_cyc - acc_cyc), 32'(S + O + 3));
    check("w_mv", 32'(mv_n - m0), 32'(1));
    check("w_start", 32'(start_n - s0), 32'(1));
    check("w_stop", 32'(stop_n - p0), 32'(1));

    // Round 2: empty frame yields one none beat.
    exp_q.push_back(mk(0, 0, 0, 0, 1'b1, 1'b1));
    offer(EMPTY);
    wait_last(2);
    @(posedge clk);
    @(negedge clk);
    check("idle_ready_after_none", 32'(syndrome_ready), 32'(1));
    check("idle_not_busy", 32'(busy), 32'(0));

    // Round 3: five defects under 1-in-3 backpressure.
    bp_mode = 1'b1;
    push_five();
    offer(FRAME5);
    wait_last(3);
    bp_mode = 1'b0;

    // Round 4: reset asserted mid-RUN aborts the round.
    s0 = start_n;
    offer(FRAME5);
    for (int k = 0; k < 400 && start_n == s0; k++) @(negedge clk);
    check("abort_start_seen", 32'(start_n - s0), 32'(1));
    repeat (500) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_pulses", 32'({measurement_valid_out, start_offer, stop_offer}), 32'(0));
    check("abort_result_valid", 32'(result_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ready_low", 32'(syndrome_ready), 32'(0));
    aborted_n++;
    p0 = stop_n;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", 32'(syndrome_ready), 32'(1));
    repeat (3000) @(negedge clk);
    check("abort_no_stop", 32'(stop_n), 32'(p0));

    // Round 5/6: valid held high across two frames.
    push_five();
    exp_q.push_back(mk(0, 0, 0, 0, 1'b1, 1'b1));
    frame_q.push_back(FRAME5);
    frame_q.push_back(EMPTY);
    base = accept_n;
    @(posedge clk);
    #1;
    syndrome_in    = FRAME5;
    syndrome_valid = 1'b1;
    wait_accept(base + 1);
    syndrome_in = EMPTY;
    wait_accept(base + 2);
    syndrome_valid = 1'b0;
    wait_last(5);

    repeat (5) @(negedge clk);
    check("beats_drained", 32'(exp_q.size()), 32'(0));
    check("frames_drained", 32'(frame_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_round_controller.md
# decoder_round_controller

Sequencing front-end and result back-end for the single-grid union-find decoder (`top_single_5_by_5_x`, 4 rows x 5 columns of X stabilizers). Accepts one syndrome frame per decoding round, loads it into the grid with a one-cycle `measurement_valid` pulse, and times the `start_offer` / `stop_offer` window. It then snapshots every node's `measurement` flag and `match_value`, and streams one result beat per defect over a valid/ready interface. It replaces the hand-timed stimulus sequence and makes the grid usable from a host or DMA stream.

## Interface
Parameters:
- `GRID_ROWS`, 4: grid rows (y).
- `GRID_COLS`, 5: grid columns (x); N = GRID_ROWS*GRID_COLS.
- `CORDINATE_WIDTH`, 3: width of one coordinate in a match value.
- `MATCH_VALUE_WIDTH`, 6: must equal 2*CORDINATE_WIDTH; `{y,x}`.
- `SETTLE_CYCLES`, 100: idle cycles between the load pulse and `start_offer`; must be >=1.
- `OFFER_CYCLES`, 2500: cycles between `start_offer` and `stop_offer`; must be >=1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `syndrome_in` in N: frame; bit y*GRID_COLS+x = node (y,x).
- `syndrome_valid` in 1: frame offered.
- `syndrome_ready` out 1: high only in IDLE.
- `measurement_value_out` out N: to every grid `measurement_value_in_y_x`.
- `measurement_valid_out` out 1: to every grid `measurement_valid_in_y_x`.
- `start_offer` out 1: one-cycle pulse to grid.
- `stop_offer` out 1: one-cycle pulse to grid.
- `measurement_in` in N: grid `measurement_y_x`, same bit order.
- `match_value_in` in N*MATCH_VALUE_WIDTH: grid `match_value_out_y_x`; slice k = bits [k*MVW +: MVW].
- `result_valid` out 1; `result_ready` in 1: result handshake.
- `result_y`, `result_x` out CORDINATE_WIDTH: defect node.
- `result_match_y`, `result_match_x` out CORDINATE_WIDTH: matched node.
- `result_last` out 1: final beat of the round.
- `result_none` out 1: round had zero defects (single beat, coordinates 0).
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, LOAD, SETTLE, START, RUN, STOP, CAPTURE, SCAN, EMIT.
- IDLE: `syndrome_ready`=1. On `syndrome_valid && syndrome_ready`: register `syndrome_in` into `measurement_value_out` and go to LOAD.
- LOAD (1 cycle): `measurement_valid_out`=1. Load counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: decrement the counter. At 0, go to START.
- START (1 cycle): `start_offer`=1. Load counter with OFFER_CYCLES-1 and go to RUN.
- RUN: decrement the counter. At 0, go to STOP.
- STOP (1 cycle): `stop_offer`=1, then go to CAPTURE.
- CAPTURE (1 cycle): snapshot `measurement_in` and `match_value_in` into internal registers. Clear the scan index and the emitted-flag, then go to SCAN.
- SCAN: examine snapshot bit at the index, one index per cycle, row-major order.
  - If the bit is set: load the result registers (y = index/GRID_COLS, x = index%GRID_COLS, match = `{upper, lower}` halves of the slice). `result_last`=1 iff no set bit exists above the index. Go to EMIT.
  - If the index passes N-1 with nothing emitted: load a `result_none`=1, `result_last`=1 beat and go to EMIT.
- EMIT: `result_valid`=1, all result fields held stable until `result_ready`. On the handshake: if `result_last`, go to IDLE; else index+1 and go to SCAN.
- The counter is wide enough for max(SETTLE_CYCLES, OFFER_CYCLES). Coordinates come from a registered row/column pair incremented with column wrap, not from a divider.
- The grid inputs after CAPTURE are ignored until the next round.

## Timing
- Reset (async assert, sync-free release) forces IDLE, and every output to 0 except `syndrome_ready`. `syndrome_ready` is 0 while `reset`=0 and 1 on the first cycle after release.
- A reset mid-round aborts immediately: pulses drop, and the snapshot and result are discarded.
- Accept at edge T:
  - `measurement_valid_out` high in cycle T+1.
  - `start_offer` high in cycle T+2+SETTLE_CYCLES.
  - `stop_offer` high exactly OFFER_CYCLES+1 cycles after `start_offer`.
  - CAPTURE is the cycle after `stop_offer`, sampling the grid at its end.
- The first scan cycle is the cycle after CAPTURE. Each zero bit costs 1 cycle; each defect costs 1 SCAN cycle plus >=1 EMIT cycle.
- `result_ready` may be high before `result_valid`. A beat transfers on the edge where both are high.
- `measurement_value_out` holds its value until the next accept.

## Test plan
- Reset: hold `reset`=0 mid-RUN -> all pulses and `result_valid` 0 at once. After release, `syndrome_ready`=1 and no `stop_offer` ever appears for the aborted round.
- Timing: SETTLE_CYCLES=100, OFFER_CYCLES=2500, accept at cycle 0 -> `measurement_valid_out` at cycle 1, `start_offer` at 102, `stop_offer` at 2603, each exactly 1 cycle wide.
- Five defects with a grid stub:
  - Frame has defects (0,0),(0,1),(2,2),(2,3),(3,0).
  - Stub reports `measurement_in` = the frame and matches (0,1),(0,0),(2,3),(2,2),(3,0).
  - Expect 5 beats in that order; only (3,0) carries `result_last`=1; match fields as given.
- Empty frame -> one beat with `result_none`=1, `result_last`=1, all coordinates 0, then `syndrome_ready`=1.
- Backpressure: `result_ready` toggles 1-of-3 cycles during the five-defect case -> no beat lost or duplicated, and fields stay stable while `result_valid`=1 and `result_ready`=0.
- Back-to-back rounds: `syndrome_valid` held high across 2 frames -> the second accept occurs only in IDLE after the first round's last beat. `measurement_value_out` changes only at that accept.
